vmode_sched: RTL and testbench
==============================

# vmode_sched

Video-mode scheduler for the raster sync generator. Holds a shadow set of timing registers written by the host and validates them on a commit request. Swaps them into the generator only at a frame boundary, holding the generator in reset for a fixed number of cycles, so a mode change never produces a torn frame. Sits between the host configuration bus and the sync generator's timing inputs and reset.

## Interface
- X_BITS, 12, width of horizontal timing values and counts
- Y_BITS, 12, width of vertical timing values and counts
- HOLD_CYC, 4, cycles `vg_reset` is held during a swap (≥1)

- clk  in  1  video pixel clock
- reset_n  in  1  asynchronous, active-low reset
- cfg_we  in  1  shadow register write strobe
- cfg_addr  in  4  0 h_total, 1 h_fp, 2 h_bp, 3 h_sync, 4 hv_offset, 5 v_total, 6 v_fp, 7 v_bp, 8 v_sync
- cfg_wdata  in  16  write data; truncated to X_BITS or Y_BITS
- commit_req  in  1  level request to apply the shadow set
- commit_ack  out  1  one-cycle pulse: commit finished, applied or rejected
- err_out  out  1  last commit rejected
- busy  out  1  state ≠ IDLE
- vg_h_count, vg_v_count  in  X_BITS/Y_BITS  generator's registered count outputs
- vg_reset  out  1  active-high reset to the generator
- h_total, h_fp, h_bp, h_sync, hv_offset  out  X_BITS  active horizontal timing
- v_total, v_fp, v_bp, v_sync  out  Y_BITS  active vertical timing

## Operation
- Reset values: all shadow and active registers 0; `vg_reset`=1; `commit_ack`=0; `err_out`=0; `busy`=0; `run`=0; `armed`=1. `run` is an internal flag meaning "generator running".
- Shadow writes:
  - A write is accepted only in IDLE.
  - Writes with `busy`=1 or `cfg_addr`>8 are ignored.
- States: IDLE → CHECK → (WAIT_EOF | HOLD) → IDLE.
- IDLE:
  - If `commit_req`=1 and `armed`=1, go to CHECK and clear `armed`.
  - `armed` sets again whenever `commit_req`=0 is sampled in IDLE, so each request level gives exactly one commit.
- CHECK validates the shadow set using X_BITS+2 / Y_BITS+2 arithmetic. Rules:
  - h_total ≥ 2
  - h_sync+h_bp+h_fp < h_total
  - hv_offset < h_total
  - v_total ≥ 2
  - v_sync+v_bp+v_fp < v_total
- CHECK outcome:
  - Fail: set `err_out`, pulse `commit_ack`, return to IDLE. Active registers are unchanged.
  - Pass with `run`=1: go to WAIT_EOF.
  - Pass with `run`=0: go straight to HOLD.
- WAIT_EOF:
  - Wait until vg_h_count==h_total−1 and vg_v_count==v_total−1, compared against the active values.
  - On that cycle, go to HOLD.
- HOLD:
  - On entry, copy shadow to active and assert `vg_reset`=1.
  - Count HOLD_CYC cycles, then go to IDLE with `vg_reset`=0.
  - On IDLE entry: `run`=1, `commit_ack` pulses, `err_out` clears.
- A commit with an identical set still performs the full swap.

## Timing
- All outputs are registered.
- Stopped generator, commit_req rises in cycle 0:
  - CHECK in cycle 1.
  - HOLD in cycles 2..HOLD_CYC+1, with active outputs updated from cycle 2.
  - `vg_reset`=0 and `commit_ack`=1 in cycle HOLD_CYC+2.
- Running generator: HOLD begins the cycle after the last-pixel match. Because of the generator's 1-cycle count lag, at most the first blanking pixel of the next frame is emitted; no active pixel of a torn frame is emitted.
- Rejection: `commit_ack` and `err_out` rise in cycle 2.
- Asynchronous reset mid-operation: all state returns to reset values immediately and the generator is held in reset.
- `commit_req` dropping before ack does not abort a commit in progress.

## Structure
- Shared package `vmode_pkg`:
  - register address constants
  - state enum {IDLE, CHECK, WAIT_EOF, HOLD}
  - HOLD counter width
- Natural sub-module: `vmode_check`, the combinational validator (shadow set in, pass out), reusable by host-side firmware models.

## Test plan
- Write 640x480 (h_total=800, h_fp=16, h_bp=48, h_sync=96, v_total=525, v_fp=10, v_bp=33, v_sync=2), commit from reset:
  - outputs update in cycle 2
  - `vg_reset` falls and ack pulses in cycle 6 (HOLD_CYC=4)
  - `err_out`=0
- Commit h_sync+h_bp+h_fp=800 with h_total=800:
  - ack in cycle 2 with `err_out`=1
  - active set unchanged; `vg_reset` unaffected
- Running 640x480 generator, commit a new set mid-frame:
  - no change until vg counts reach (799,524)
  - `vg_reset`=1 the next cycle for 4 cycles
- Hold `commit_req` high for 50 cycles: exactly one ack. Drop then raise again: a second commit runs.
- Write during WAIT_EOF and write to cfg_addr=12: shadow is unchanged (verified by the applied values).
- Assert `reset_n` low during HOLD: `vg_reset`=1, all active regs=0, `busy`=0 immediately.

Source files
------------

// File: rtl/vmode_pkg.sv
// Shared definitions for the video-mode scheduler: register map, FSM states
// and the swap-hold counter width.
package vmode_pkg;

    localparam logic [3:0] ADDR_H_TOTAL   = 4'd0;
    localparam logic [3:0] ADDR_H_FP      = 4'd1;
    localparam logic [3:0] ADDR_H_BP      = 4'd2;
    localparam logic [3:0] ADDR_H_SYNC    = 4'd3;
    localparam logic [3:0] ADDR_HV_OFFSET = 4'd4;
    localparam logic [3:0] ADDR_V_TOTAL   = 4'd5;
    localparam logic [3:0] ADDR_V_FP      = 4'd6;
    localparam logic [3:0] ADDR_V_BP      = 4'd7;
    localparam logic [3:0] ADDR_V_SYNC    = 4'd8;

    typedef enum logic [1:0] {
        IDLE,
        CHECK,
        WAIT_EOF,
        HOLD
    } state_e;

    // Wide enough for any practical HOLD_CYC (up to 256).
    localparam int HOLD_CNT_W = 8;

endpackage

// File: rtl/vmode_sched_if.sv
// Host configuration bus of the video-mode scheduler: shadow register writes
// plus the commit request/acknowledge handshake.
interface vmode_sched_if;

    logic        cfg_we;
    logic [3:0]  cfg_addr;
    logic [15:0] cfg_wdata;
    logic        commit_req;
    logic        commit_ack;
    logic        err_out;
    logic        busy;

    modport master (
        output cfg_we, cfg_addr, cfg_wdata, commit_req,
        input  commit_ack, err_out, busy
    );

    modport slave (
        input  cfg_we, cfg_addr, cfg_wdata, commit_req,
        output commit_ack, err_out, busy
    );

endinterface

// File: rtl/vmode_check.sv
// Combinational validator for a raster timing set; sums are taken two bits
// wider than the fields so three maximal values can never wrap.
module vmode_check #(
    parameter int X_BITS = 12,
    parameter int Y_BITS = 12
) (
    input  logic [X_BITS-1:0] h_total,
    input  logic [X_BITS-1:0] h_fp,
    input  logic [X_BITS-1:0] h_bp,
    input  logic [X_BITS-1:0] h_sync,
    input  logic [X_BITS-1:0] hv_offset,
    input  logic [Y_BITS-1:0] v_total,
    input  logic [Y_BITS-1:0] v_fp,
    input  logic [Y_BITS-1:0] v_bp,
    input  logic [Y_BITS-1:0] v_sync,
    output logic              pass
);

    localparam int XW = X_BITS + 2;
    localparam int YW = Y_BITS + 2;

    logic [XW-1:0] h_sum;
    logic [YW-1:0] v_sum;

    always_comb begin
        h_sum = XW'(h_sync) + XW'(h_bp) + XW'(h_fp);
        v_sum = YW'(v_sync) + YW'(v_bp) + YW'(v_fp);
        pass  = (h_total >= X_BITS'(2))
             && (h_sum < XW'(h_total))
             && (hv_offset < h_total)
             && (v_total >= Y_BITS'(2))
             && (v_sum < YW'(v_total));
    end

endmodule

// File: rtl/vmode_sched.sv
// Video-mode scheduler: validates a host-written shadow timing set and swaps
// it into the sync generator only at a frame boundary, under generator reset.
module vmode_sched
    import vmode_pkg::*;
#(
    parameter int X_BITS   = 12,
    parameter int Y_BITS   = 12,
    parameter int HOLD_CYC = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    vmode_sched_if.slave      host,
    input  logic [X_BITS-1:0] vg_h_count,
    input  logic [Y_BITS-1:0] vg_v_count,
    output logic              vg_reset,
    output logic [X_BITS-1:0] h_total,
    output logic [X_BITS-1:0] h_fp,
    output logic [X_BITS-1:0] h_bp,
    output logic [X_BITS-1:0] h_sync,
    output logic [X_BITS-1:0] hv_offset,
    output logic [Y_BITS-1:0] v_total,
    output logic [Y_BITS-1:0] v_fp,
    output logic [Y_BITS-1:0] v_bp,
    output logic [Y_BITS-1:0] v_sync
);

    typedef struct packed {
        logic [X_BITS-1:0] h_total;
        logic [X_BITS-1:0] h_fp;
        logic [X_BITS-1:0] h_bp;
        logic [X_BITS-1:0] h_sync;
        logic [X_BITS-1:0] hv_offset;
        logic [Y_BITS-1:0] v_total;
        logic [Y_BITS-1:0] v_fp;
        logic [Y_BITS-1:0] v_bp;
        logic [Y_BITS-1:0] v_sync;
    } timing_t;

    timing_t                 shadow_q,   shadow_d;
    timing_t                 active_q,   active_d;
    state_e                  state_q,    state_d;
    logic [HOLD_CNT_W-1:0]   hold_cnt_q, hold_cnt_d;
    logic                    armed_q,    armed_d;
    logic                    run_q,      run_d;
    logic                    ack_q,      ack_d;
    logic                    err_q,      err_d;
    logic                    busy_q,     busy_d;
    logic                    vg_reset_q, vg_reset_d;

    logic                    check_pass;
    logic                    at_eof;
    logic                    load_active;
    logic [X_BITS-1:0]       wdata_x;
    logic [Y_BITS-1:0]       wdata_y;

    vmode_check #(
        .X_BITS (X_BITS),
        .Y_BITS (Y_BITS)
    ) u_check (
        .h_total   (shadow_q.h_total),
        .h_fp      (shadow_q.h_fp),
        .h_bp      (shadow_q.h_bp),
        .h_sync    (shadow_q.h_sync),
        .hv_offset (shadow_q.hv_offset),
        .v_total   (shadow_q.v_total),
        .v_fp      (shadow_q.v_fp),
        .v_bp      (shadow_q.v_bp),
        .v_sync    (shadow_q.v_sync),
        .pass      (check_pass)
    );

    assign wdata_x = host.cfg_wdata[X_BITS-1:0];
    assign wdata_y = host.cfg_wdata[Y_BITS-1:0];

    // Last pixel of the frame as seen through the generator's registered counts.
    assign at_eof = (vg_h_count == active_q.h_total - X_BITS'(1))
                 && (vg_v_count == active_q.v_total - Y_BITS'(1));

    always_comb begin
        // NOTE: every signal written here gets a default first so no latch is inferred.
        shadow_d    = shadow_q;
        active_d    = active_q;
        state_d     = state_q;
        hold_cnt_d  = hold_cnt_q;
        armed_d     = armed_q;
        run_d       = run_q;
        ack_d       = 1'b0;
        err_d       = err_q;
        vg_reset_d  = vg_reset_q;
        load_active = 1'b0;

        if (host.cfg_we && (state_q == IDLE)) begin
            case (host.cfg_addr)
                ADDR_H_TOTAL:   shadow_d.h_total   = wdata_x;
                ADDR_H_FP:      shadow_d.h_fp      = wdata_x;
                ADDR_H_BP:      shadow_d.h_bp      = wdata_x;
                ADDR_H_SYNC:    shadow_d.h_sync    = wdata_x;
                ADDR_HV_OFFSET: shadow_d.hv_offset = wdata_x;
                ADDR_V_TOTAL:   shadow_d.v_total   = wdata_y;
                ADDR_V_FP:      shadow_d.v_fp      = wdata_y;
                ADDR_V_BP:      shadow_d.v_bp      = wdata_y;
                ADDR_V_SYNC:    shadow_d.v_sync    = wdata_y;
                default: ;
            endcase
        end

        case (state_q)
            IDLE: begin
                // One commit per request level: re-arm only once the level drops.
                if (!host.commit_req) begin
                    armed_d = 1'b1;
                end else if (armed_q) begin
                    armed_d = 1'b0;
                    state_d = CHECK;
                end
            end
            CHECK: begin
                if (!check_pass) begin
                    err_d   = 1'b1;
                    ack_d   = 1'b1;
                    state_d = IDLE;
                end else if (run_q) begin
                    state_d = WAIT_EOF;
                end else begin
                    load_active = 1'b1;
                end
            end
            WAIT_EOF: begin
                if (at_eof) begin
                    load_active = 1'b1;
                end
            end
            HOLD: begin
                if (hold_cnt_q == HOLD_CNT_W'(HOLD_CYC - 1)) begin
                    state_d    = IDLE;
                    vg_reset_d = 1'b0;
                    run_d      = 1'b1;
                    ack_d      = 1'b1;
                    err_d      = 1'b0;
                end else begin
                    hold_cnt_d = hold_cnt_q + HOLD_CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        if (load_active) begin
            state_d    = HOLD;
            active_d   = shadow_q;
            vg_reset_d = 1'b1;
            hold_cnt_d = '0;
        end

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            // NOTE: shadow and active sets are ordinary registers with a defined reset, not a memory.
            shadow_q   <= '0;
            active_q   <= '0;
            state_q    <= IDLE;
            hold_cnt_q <= '0;
            armed_q    <= 1'b1;
            run_q      <= 1'b0;
            ack_q      <= 1'b0;
            err_q      <= 1'b0;
            busy_q     <= 1'b0;
            vg_reset_q <= 1'b1;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            shadow_q   <= shadow_d;
            active_q   <= active_d;
            state_q    <= state_d;
            hold_cnt_q <= hold_cnt_d;
            armed_q    <= armed_d;
            run_q      <= run_d;
            ack_q      <= ack_d;
            err_q      <= err_d;
            busy_q     <= busy_d;
            vg_reset_q <= vg_reset_d;
        end
    end

    assign host.commit_ack = ack_q;
    assign host.err_out    = err_q;
    assign host.busy       = busy_q;
    assign vg_reset        = vg_reset_q;
    assign h_total         = active_q.h_total;
    assign h_fp            = active_q.h_fp;
    assign h_bp            = active_q.h_bp;
    assign h_sync          = active_q.h_sync;
    assign hv_offset       = active_q.hv_offset;
    assign v_total         = active_q.v_total;
    assign v_fp            = active_q.v_fp;
    assign v_bp            = active_q.v_bp;
    assign v_sync          = active_q.v_sync;

endmodule

// File: tb/tb_vmode_sched.sv
// Directed + randomized bench for vmode_sched against a register-set model
// that applies the validation rules with plain integer arithmetic.
module tb_vmode_sched;

    localparam int HOLD_CYC = 4;

    logic        clk = 1'b0;
    logic        reset_n = 1'b1;
    logic [11:0] vg_h_count = '0;
    logic [11:0] vg_v_count = '0;
    logic        vg_reset;
    logic [11:0] h_total, h_fp, h_bp, h_sync, hv_offset;
    logic [11:0] v_total, v_fp, v_bp, v_sync;

    vmode_sched_if host_if ();

    vmode_sched #(
        .X_BITS   (12),
        .Y_BITS   (12),
        .HOLD_CYC (HOLD_CYC)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .host       (host_if),
        .vg_h_count (vg_h_count),
        .vg_v_count (vg_v_count),
        .vg_reset   (vg_reset),
        .h_total    (h_total),
        .h_fp       (h_fp),
        .h_bp       (h_bp),
        .h_sync     (h_sync),
        .hv_offset  (hv_offset),
        .v_total    (v_total),
        .v_fp       (v_fp),
        .v_bp       (v_bp),
        .v_sync     (v_sync)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Model: register images indexed by cfg_addr.
    int  sh[9];
    int  act[9];
    int  rnd[9];
    bit  running_m;
    int  vga[9]  = '{800, 16, 48, 96, 0, 525, 10, 33, 2};
    int  svga[9] = '{1056, 40, 88, 128, 8, 628, 1, 23, 4};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic bit valid_set(input int s[9]);
        return (s[0] >= 2) && (s[3] + s[2] + s[1] < s[0]) && (s[4] < s[0])
            && (s[5] >= 2) && (s[8] + s[7] + s[6] < s[5]);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_active(input string tag);
        check({tag, ".h_total"},   32'(h_total),   32'(act[0]));
        check({tag, ".h_fp"},      32'(h_fp),      32'(act[1]));
        check({tag, ".h_bp"},      32'(h_bp),      32'(act[2]));
        check({tag, ".h_sync"},    32'(h_sync),    32'(act[3]));
        check({tag, ".hv_offset"}, 32'(hv_offset), 32'(act[4]));
        check({tag, ".v_total"},   32'(v_total),   32'(act[5]));
        check({tag, ".v_fp"},      32'(v_fp),      32'(act[6]));
        check({tag, ".v_bp"},      32'(v_bp),      32'(act[7]));
        check({tag, ".v_sync"},    32'(v_sync),    32'(act[8]));
    endtask

    // 'accepted' is the bench's knowledge of whether the scheduler is idle.
    task automatic cfg_write(input int addr, input int data, input bit accepted);
        host_if.cfg_we    = 1'b1;
        host_if.cfg_addr  = 4'(addr);
        host_if.cfg_wdata = 16'(data);
        tick();
        host_if.cfg_we    = 1'b0;
        if (accepted && addr <= 8) sh[addr] = data & 32'hFFF;
    endtask

    task automatic write_set(input int s[9]);
        for (int i = 0; i < 9; i++) cfg_write(i, s[i], 1'b1);
    endtask

    // Hold the generator in its final HOLD cycles and check the release.
    task automatic finish_hold(input string tag);
        repeat (HOLD_CYC - 1) begin
            tick();
            check({tag, ".hold_vg_reset"}, 32'(vg_reset), 32'd1);
        end
        tick();
        check({tag, ".ack"},      32'(host_if.commit_ack), 32'd1);
        check({tag, ".vg_reset"}, 32'(vg_reset),           32'd0);
        check({tag, ".err"},      32'(host_if.err_out),    32'd0);
        check({tag, ".busy"},     32'(host_if.busy),       32'd0);
        running_m = 1'b1;
    endtask

    // Full commit from an armed IDLE, dropping the request afterwards.
    task automatic run_commit(input string tag);
        bit exp_ok;
        int n;
        exp_ok = valid_set(sh);
        host_if.commit_req = 1'b1;
        tick();
        check({tag, ".busy_c1"}, 32'(host_if.busy), 32'd1);
        tick();
        if (!exp_ok) begin
            check({tag, ".rej_ack"},      32'(host_if.commit_ack), 32'd1);
            check({tag, ".rej_err"},      32'(host_if.err_out),    32'd1);
            check({tag, ".rej_vg_reset"}, 32'(vg_reset),           32'(!running_m));
            check_active({tag, ".rej"});
        end else if (!running_m) begin
            act = sh;
            check({tag, ".vg_reset_c2"}, 32'(vg_reset), 32'd1);
            check_active({tag, ".c2"});
            finish_hold(tag);
        end else begin
            check({tag, ".wait_busy"}, 32'(host_if.busy), 32'd1);
            n = $urandom_range(0, 6);
            repeat (n) begin
                vg_h_count = 12'($urandom_range(0, act[0] - 2));
                vg_v_count = 12'($urandom_range(0, act[5] - 1));
                tick();
                check({tag, ".wait_vg_reset"}, 32'(vg_reset), 32'd0);
            end
            vg_h_count = 12'(act[0] - 1);
            vg_v_count = 12'(act[5] - 1);
            tick();
            vg_h_count = '0;
            vg_v_count = '0;
            act = sh;
            check({tag, ".swap_vg_reset"}, 32'(vg_reset), 32'd1);
            check_active({tag, ".swap"});
            finish_hold(tag);
        end
        host_if.commit_req = 1'b0;
        tick();
        check({tag, ".ack_pulse"}, 32'(host_if.commit_ack), 32'd0);
    endtask

    initial begin
        int acks;
        host_if.cfg_we     = 1'b0;
        host_if.cfg_addr   = '0;
        host_if.cfg_wdata  = '0;
        host_if.commit_req = 1'b0;
        sh  = '{default: 0};
        act = '{default: 0};
        running_m = 1'b0;

        #1 reset_n = 1'b0;
        #2;
        check("rst.vg_reset", 32'(vg_reset),           32'd1);
        check("rst.ack",      32'(host_if.commit_ack), 32'd0);
        check("rst.err",      32'(host_if.err_out),    32'd0);
        check("rst.busy",     32'(host_if.busy),       32'd0);
        check_active("rst");
        #10 reset_n = 1'b1;
        tick();

        // 640x480 from a stopped generator; h_total written with junk upper bits.
        write_set(vga);
        cfg_write(0, 32'hF320, 1'b1);
        host_if.commit_req = 1'b1;
        tick();
        check("vga.busy_c1", 32'(host_if.busy), 32'd1);
        check("vga.h_total_c1", 32'(h_total), 32'd0);
        tick();
        act = sh;
        check("vga.vg_reset_c2", 32'(vg_reset), 32'd1);
        check_active("vga.c2");
        finish_hold("vga");
        // Keep the level high: no further commit may start.
        acks = 0;
        repeat (44) begin
            tick();
            if (host_if.commit_ack) acks++;
        end
        check("hold50.extra_acks", 32'(acks), 32'd0);
        check("hold50.busy", 32'(host_if.busy), 32'd0);
        host_if.commit_req = 1'b0;
        tick();

        // Second request level: identical set, full swap at end of frame.
        run_commit("recommit");

        // Rejections: blanking fills the whole line, then a sum that wraps 12 bits.
        cfg_write(3, 736, 1'b1);
        run_commit("rej_sum");
        check("rej_sum.err_holds", 32'(host_if.err_out), 32'd1);
        write_set('{4095, 4095, 4095, 4095, 0, 525, 10, 33, 2});
        run_commit("rej_wrap");
        write_set(vga);

        // Mid-frame commit of 800x600 with ignored writes while waiting.
        write_set(svga);
        cfg_write(12, 16'h0123, 1'b1);
        vg_h_count = 12'd100;
        vg_v_count = 12'd200;
        host_if.commit_req = 1'b1;
        tick();
        tick();
        check("mid.busy", 32'(host_if.busy), 32'd1);
        cfg_write(0, 5, 1'b0);
        cfg_write(12, 7, 1'b0);
        host_if.commit_req = 1'b0;
        for (int i = 0; i < 4; i++) begin
            vg_h_count = (i == 1) ? 12'd798 : (i == 2) ? 12'd0 : 12'd799;
            vg_v_count = (i == 0) ? 12'd523 : (i == 3) ? 12'd0 : 12'd524;
            tick();
            check("mid.near_vg_reset", 32'(vg_reset), 32'd0);
            check("mid.near_h_total",  32'(h_total),  32'(act[0]));
        end
        vg_h_count = 12'd799;
        vg_v_count = 12'd524;
        tick();
        vg_h_count = '0;
        vg_v_count = '0;
        act = sh;
        check("mid.swap_vg_reset", 32'(vg_reset), 32'd1);
        check_active("mid.swap");
        finish_hold("mid");
        tick();

        // Asynchronous reset while holding the generator.
        vg_h_count = 12'(act[0] - 1);
        vg_v_count = 12'(act[5] - 1);
        host_if.commit_req = 1'b1;
        repeat (3) tick();
        check("arst.pre_vg_reset", 32'(vg_reset), 32'd1);
        #2 reset_n = 1'b0;
        #1;
        sh  = '{default: 0};
        act = '{default: 0};
        running_m = 1'b0;
        check("arst.vg_reset", 32'(vg_reset),           32'd1);
        check("arst.busy",     32'(host_if.busy),       32'd0);
        check("arst.ack",      32'(host_if.commit_ack), 32'd0);
        check_active("arst");
        host_if.commit_req = 1'b0;
        vg_h_count = '0;
        vg_v_count = '0;
        #3 reset_n = 1'b1;
        tick();

        // Randomized sets, a mix of valid and rejected, starting stopped.
        for (int it = 0; it < 10; it++) begin
            rnd[0] = $urandom_range(2, 40);
            rnd[1] = $urandom_range(0, rnd[0] / 2);
            rnd[2] = $urandom_range(0, rnd[0] / 2);
            rnd[3] = $urandom_range(0, rnd[0] / 2);
            rnd[4] = $urandom_range(0, rnd[0]);
            rnd[5] = $urandom_range(2, 40);
            rnd[6] = $urandom_range(0, rnd[5] / 2);
            rnd[7] = $urandom_range(0, rnd[5] / 2);
            rnd[8] = $urandom_range(0, rnd[5] / 2);
            write_set(rnd);
            run_commit("rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
